// File: rtl/cursor_line_fetch.sv
// Cursor sprite line fetcher: streams one sprite row from a 1-cycle-latency ROM
// into a line buffer per scanline, then serves per-pixel index, opacity and fade alpha.
module cursor_line_fetch #(
  parameter int SPR_W       = 64,
  parameter int SPR_H       = 64,
  parameter int DATA_W      = 4,
  parameter int TRANSPARENT = 0,
  parameter int FADE_STEP   = 1,
  parameter int MIN_ALPHA   = 4,
  localparam int AW         = $clog2(SPR_W * SPR_H),
  localparam int CW         = $clog2(SPR_W)
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              frame_start_i,
  input  logic              line_start_i,
  input  logic [9:0]        line_y_i,
  input  logic [9:0]        cursor_x_i,
  input  logic [9:0]        cursor_y_i,
  input  logic              click_i,
  input  logic [9:0]        draw_x_i,
  output logic [AW-1:0]     rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] pix_idx_o,
  output logic              pix_opaque_o,
  output logic [3:0]        pix_alpha_o,
  output logic              busy_o,
  output logic              line_valid_o
);

  typedef enum logic {IDLE, FETCH} state_e;

  localparam logic [CW:0] COL_ONE = (CW + 1)'(1);
  localparam logic [CW:0] COL_END = (CW + 1)'(SPR_W);

  state_e            state_q, state_d;
  logic [CW:0]       col_q, col_d;
  logic [AW-1:0]     romAddr_q, romAddr_d;
  logic [AW-1:0]     rowBase_q, rowBase_d;
  logic              issue_q, issue_d;
  logic              cap_q, cap_d;
  logic [CW-1:0]     capIdx_q, capIdx_d;
  logic              lineValid_q, lineValid_d;
  logic [9:0]        cx_q, cx_d, cy_q, cy_d;
  logic [3:0]        alpha_q, alpha_d;
  logic [DATA_W-1:0] pixIdx_q, pixIdx_d;
  logic              pixOpaque_q, pixOpaque_d;
  logic [DATA_W-1:0] lineBuf_q [SPR_W];

  logic [10:0]       row, dx;
  logic              inRange, inCol;
  logic [AW-1:0]     newBase;
  logic [DATA_W-1:0] bufRd;

  assign row     = {1'b0, line_y_i} - {1'b0, cy_q};
  assign inRange = (line_y_i >= cy_q) && (row < 11'(SPR_H));
  assign newBase = AW'(row) << CW;

  assign dx      = {1'b0, draw_x_i} - {1'b0, cx_q};
  assign inCol   = (draw_x_i >= cx_q) && (dx < 11'(SPR_W));
  assign bufRd   = lineBuf_q[dx[CW-1:0]];

  // issue_q marks a cycle whose rom_addr is a live fetch; cap_q is that flag
  // delayed by the ROM latency, so rom_data lines up with capIdx_q.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    romAddr_d   = romAddr_q;
    rowBase_d   = rowBase_q;
    issue_d     = 1'b0;
    cap_d       = issue_q;
    capIdx_d    = CW'(col_q - COL_ONE);
    lineValid_d = lineValid_q;
    if (line_start_i) begin
      cap_d       = 1'b0;
      lineValid_d = 1'b0;
      if (inRange) begin
        state_d   = FETCH;
        col_d     = COL_ONE;
        romAddr_d = newBase;
        rowBase_d = newBase;
        issue_d   = 1'b1;
      end else begin
        state_d = IDLE;
        col_d   = '0;
      end
    end else if (state_q == FETCH) begin
      if (col_q < COL_END) begin
        romAddr_d = rowBase_q + AW'(col_q);
        col_d     = col_q + COL_ONE;
        issue_d   = 1'b1;
      end
      if (cap_q && (capIdx_q == CW'(SPR_W - 1))) begin
        state_d     = IDLE;
        lineValid_d = 1'b1;
        col_d       = '0;
      end
    end
  end

  // Click wins over the per-frame fade; the fade floors at MIN_ALPHA.
  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    alpha_d = alpha_q;
    if (frame_start_i) begin
      cx_d = cursor_x_i;
      cy_d = cursor_y_i;
    end
    if (click_i) begin
      alpha_d = 4'd15;
    end else if (frame_start_i) begin
      alpha_d = (int'(alpha_q) >= FADE_STEP + MIN_ALPHA) ? alpha_q - 4'(FADE_STEP)
                                                          : 4'(MIN_ALPHA);
    end
    pixIdx_d    = (lineValid_q && inCol) ? bufRd : '0;
    pixOpaque_d = lineValid_q && inCol && (bufRd != DATA_W'(TRANSPARENT));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      col_q       <= '0;
      romAddr_q   <= '0;
      rowBase_q   <= '0;
      issue_q     <= 1'b0;
      cap_q       <= 1'b0;
      capIdx_q    <= '0;
      lineValid_q <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
      alpha_q     <= 4'd15;
      pixIdx_q    <= '0;
      pixOpaque_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      romAddr_q   <= romAddr_d;
      rowBase_q   <= rowBase_d;
      issue_q     <= issue_d;
      cap_q       <= cap_d;
      capIdx_q    <= capIdx_d;
      lineValid_q <= lineValid_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      alpha_q     <= alpha_d;
      pixIdx_q    <= pixIdx_d;
      pixOpaque_q <= pixOpaque_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cap_q) begin
      lineBuf_q[capIdx_q] <= rom_data_i;
    end
  end

  assign rom_addr_o   = romAddr_q;
  assign pix_idx_o    = pixIdx_q;
  assign pix_opaque_o = pixOpaque_q;
  assign pix_alpha_o  = alpha_q;
  assign busy_o       = (state_q == FETCH);
  assign line_valid_o = lineValid_q;

endmodule

// File: tb/tb_cursor_line_fetch.sv
// Bench for cursor_line_fetch: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a timeline-level model.
module tb_cursor_line_fetch;

  localparam int FSTEP = 2;
  localparam int MINA  = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        frameStart = 1'b0, lineStart = 1'b0, click = 1'b0;
  logic [9:0]  lineY = '0, cursorX = '0, cursorY = '0, drawX = '0;
  logic [11:0] romAddr;
  logic [3:0]  romData = '0;
  logic [3:0]  pixIdx, pixAlpha;
  logic        pixOpaque, busy, lineValid;
  logic [3:0]  romMem [4096];

  int checkCount = 0;
  int errCount   = 0;

  always #5 clk = ~clk;

  cursor_line_fetch #(
    .SPR_W(64), .SPR_H(64), .DATA_W(4), .TRANSPARENT(0),
    .FADE_STEP(FSTEP), .MIN_ALPHA(MINA)
  ) dut (
    .clk_i(clk), .reset_n_i(resetN), .frame_start_i(frameStart),
    .line_start_i(lineStart), .line_y_i(lineY), .cursor_x_i(cursorX),
    .cursor_y_i(cursorY), .click_i(click), .draw_x_i(drawX),
    .rom_addr_o(romAddr), .rom_data_i(romData), .pix_idx_o(pixIdx),
    .pix_opaque_o(pixOpaque), .pix_alpha_o(pixAlpha), .busy_o(busy),
    .line_valid_o(lineValid)
  );

  always @(posedge clk) romData <= romMem[romAddr];

  // Reference model: expected outputs after each edge, derived from the fetch
  // timeline (steps since the accepted line_start) rather than any FSM encoding.
  logic        eBusy = 1'b0, eLv = 1'b0, eOpq = 1'b0;
  logic [11:0] eAddr = '0;
  logic [3:0]  eIdx = '0, eAlpha = 4'd15;
  int          ecx = 0, ecy = 0;
  bit          fetchOn = 1'b0;
  int          fetchStep = 0, fetchBase = 0;
  int          mD, mRow, mA;
  logic [3:0]  mBuf [64];

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      eBusy = 1'b0; eLv = 1'b0; eOpq = 1'b0; eAddr = '0; eIdx = '0;
      eAlpha = 4'd15; ecx = 0; ecy = 0; fetchOn = 1'b0; fetchStep = 0;
    end else begin
      mD = int'(drawX) - ecx;
      if (eLv && mD >= 0 && mD < 64) begin
        eIdx = mBuf[mD];
        eOpq = (mBuf[mD] != 4'd0);
      end else begin
        eIdx = '0;
        eOpq = 1'b0;
      end
      if (click) eAlpha = 4'd15;
      else if (frameStart) begin
        mA = int'(eAlpha) - FSTEP;
        if (mA < MINA) mA = MINA;
        eAlpha = 4'(mA);
      end
      if (lineStart) begin
        eLv  = 1'b0;
        mRow = int'(lineY) - ecy;
        if (mRow >= 0 && mRow < 64) begin
          fetchOn = 1'b1; fetchStep = 0; fetchBase = mRow * 64;
          eAddr = 12'(fetchBase); eBusy = 1'b1;
        end else begin
          fetchOn = 1'b0; eBusy = 1'b0;
        end
      end else if (fetchOn) begin
        fetchStep++;
        if (fetchStep <= 63) eAddr = 12'(fetchBase + fetchStep);
        if (fetchStep == 65) begin
          fetchOn = 1'b0; eBusy = 1'b0; eLv = 1'b1;
          for (int i = 0; i < 64; i++) mBuf[i] = romMem[fetchBase + i];
        end
      end
      if (frameStart) begin
        ecx = int'(cursorX);
        ecy = int'(cursorY);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checkCount++;
    if (act !== want) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("m_busy",   32'(busy),      32'(eBusy));
    checkOutput("m_addr",   32'(romAddr),   32'(eAddr));
    checkOutput("m_lv",     32'(lineValid), 32'(eLv));
    checkOutput("m_idx",    32'(pixIdx),    32'(eIdx));
    checkOutput("m_opaque", 32'(pixOpaque), 32'(eOpq));
    checkOutput("m_alpha",  32'(pixAlpha),  32'(eAlpha));
  end

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitLineValid(output int n);
    n = 0;
    while (lineValid !== 1'b1 && n < 200) begin
      applyStimulus(1);
      n++;
    end
  endtask

  task automatic pulseLine(input int y);
    lineY = 10'(y);
    lineStart = 1'b1;
    applyStimulus(1);
    lineStart = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fadeExp[7] = '{13, 11, 9, 7, 5, 4, 4};
    int nBusy, guard, n, lastCx, lastCy, rnd;

    for (int i = 0; i < 4096; i++) romMem[i] = 4'($urandom_range(0, 15));
    romMem[132] = 4'd7;
    romMem[133] = 4'd0;
    romMem[134] = 4'd9;

    applyStimulus(3);
    resetN = 1'b1;
    applyStimulus(1);
    checkOutput("rst_alpha", 32'(pixAlpha), 15);
    checkOutput("rst_busy",  32'(busy), 0);
    checkOutput("rst_addr",  32'(romAddr), 0);
    checkOutput("rst_lv",    32'(lineValid), 0);

    click = 1'b1; applyStimulus(1); click = 1'b0;
    checkOutput("fade_click", 32'(pixAlpha), 15);
    cursorX = 10'd100; cursorY = 10'd50;
    for (int k = 0; k < 7; k++) begin
      frameStart = 1'b1; applyStimulus(1); frameStart = 1'b0;
      checkOutput("fade_step", 32'(pixAlpha), fadeExp[k]);
      applyStimulus(1);
    end
    click = 1'b1; frameStart = 1'b1; applyStimulus(1);
    click = 1'b0; frameStart = 1'b0;
    checkOutput("fade_click_prio", 32'(pixAlpha), 15);

    pulseLine(52);
    nBusy = 0;
    for (int k = 0; k < 64; k++) begin
      checkOutput("fetch_addr", 32'(romAddr), 128 + k);
      if (busy === 1'b1) nBusy++;
      applyStimulus(1);
    end
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      nBusy++; guard++;
      applyStimulus(1);
    end
    checkOutput("busy_len", 32'(nBusy), 65);
    checkOutput("lv_rise",  32'(lineValid), 1);

    for (int i = 0; i < 64; i++) begin
      drawX = 10'(100 + i); applyStimulus(1);
      checkOutput("sweep_idx", 32'(pixIdx), 32'(romMem[128 + i]));
      checkOutput("sweep_opq", 32'(pixOpaque), 32'(romMem[128 + i] != 4'd0));
    end
    drawX = 10'd105; applyStimulus(1);
    checkOutput("transp_idx", 32'(pixIdx), 0);
    checkOutput("transp_opq", 32'(pixOpaque), 0);
    drawX = 10'd104; applyStimulus(1);
    checkOutput("left_nb_idx", 32'(pixIdx), 7);
    checkOutput("left_nb_opq", 32'(pixOpaque), 1);
    drawX = 10'd106; applyStimulus(1);
    checkOutput("right_nb_idx", 32'(pixIdx), 9);
    checkOutput("right_nb_opq", 32'(pixOpaque), 1);
    drawX = 10'd99; applyStimulus(1);
    checkOutput("edge99_opq", 32'(pixOpaque), 0);
    drawX = 10'd164; applyStimulus(1);
    checkOutput("edge164_opq", 32'(pixOpaque), 0);

    for (int r = 0; r < 2; r++) begin
      pulseLine(r == 0 ? 49 : 114);
      checkOutput("oor_busy", 32'(busy), 0);
      checkOutput("oor_addr", 32'(romAddr), 191);
      checkOutput("oor_lv",   32'(lineValid), 0);
      for (int x = 98; x < 168; x += 6) begin
        drawX = 10'(x); applyStimulus(1);
        checkOutput("oor_opq", 32'(pixOpaque), 0);
      end
    end

    pulseLine(52);
    applyStimulus(9);
    checkOutput("abort_pre_addr", 32'(romAddr), 137);
    pulseLine(60);
    checkOutput("abort_addr", 32'(romAddr), 640);
    n = 1;
    while (lineValid !== 1'b1 && n < 200) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("abort_lv_latency", 32'(n), 66);
    for (int i = 0; i < 64; i++) begin
      drawX = 10'(100 + i); applyStimulus(1);
      checkOutput("abort_row10", 32'(pixIdx), 32'(romMem[640 + i]));
    end

    cursorX = 10'd300;
    pulseLine(52);
    waitLineValid(n);
    drawX = 10'd100; applyStimulus(1);
    checkOutput("latch_old_x_idx", 32'(pixIdx), 32'(romMem[128]));
    drawX = 10'd300; applyStimulus(1);
    checkOutput("latch_new_x_opq", 32'(pixOpaque), 0);
    frameStart = 1'b1; applyStimulus(1); frameStart = 1'b0;
    pulseLine(52);
    waitLineValid(n);
    drawX = 10'd300; applyStimulus(1);
    checkOutput("latch_after_fs_idx", 32'(pixIdx), 32'(romMem[128]));
    drawX = 10'd100; applyStimulus(1);
    checkOutput("latch_after_fs_opq", 32'(pixOpaque), 0);

    pulseLine(52);
    applyStimulus(5);
    resetN = 1'b0;
    #1;
    checkOutput("async_busy",  32'(busy), 0);
    checkOutput("async_addr",  32'(romAddr), 0);
    checkOutput("async_lv",    32'(lineValid), 0);
    checkOutput("async_alpha", 32'(pixAlpha), 15);
    checkOutput("async_idx",   32'(pixIdx), 0);
    checkOutput("async_opq",   32'(pixOpaque), 0);
    applyStimulus(2);
    resetN = 1'b1;
    applyStimulus(5);
    checkOutput("post_rst_addr", 32'(romAddr), 0);
    checkOutput("post_rst_busy", 32'(busy), 0);

    lastCx = 0; lastCy = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      frameStart = ($urandom_range(0, 199) == 0) || (cyc == 0);
      if (frameStart) begin
        lastCx = int'($urandom_range(0, 639));
        lastCy = int'($urandom_range(0, 479));
        cursorX = 10'(lastCx);
        cursorY = 10'(lastCy);
      end else if ($urandom_range(0, 9) == 0) begin
        cursorX = 10'($urandom_range(0, 639));
        cursorY = 10'($urandom_range(0, 479));
      end
      click = ($urandom_range(0, 63) == 0);
      lineStart = ($urandom_range(0, 59) == 0);
      if (lineStart) begin
        rnd = lastCy + int'($urandom_range(0, 72)) - 4;
        lineY = 10'(rnd & 1023);
      end
      if ($urandom_range(0, 1) == 1) begin
        rnd = lastCx + int'($urandom_range(0, 70)) - 3;
        drawX = 10'(rnd & 1023);
      end else begin
        drawX = 10'($urandom_range(0, 639));
      end
      applyStimulus(1);
    end
    frameStart = 1'b0; lineStart = 1'b0; click = 1'b0;
    applyStimulus(2);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
